// File: rtl/calc_entry_fsm_pkg.sv
// rtl/calc_entry_fsm_pkg.sv - shared key, operation, state and display constants
package calc_entry_fsm_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  localparam logic [1:0] CALC_RST   = 2'd0;
  localparam logic [1:0] CALC_ADD   = 2'd1;
  localparam logic [1:0] CALC_SUB   = 2'd2;
  localparam logic [1:0] CALC_MULTI = 2'd3;

  typedef enum logic [1:0] {
    STAT_ILLEGAL = 2'b00,
    STAT_RESULT  = 2'b01,
    STAT_NUM_A   = 2'b10,
    STAT_NUM_B   = 2'b11
  } stat_e;

  localparam logic DISP_ENTRY  = 1'b0;
  localparam logic DISP_RESULT = 1'b1;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= KEY_9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k == KEY_A) || (k == KEY_D) || (k == KEY_B);
  endfunction

  function automatic logic [1:0] op_code(input logic [3:0] k);
    case (k)
      KEY_A:   return CALC_ADD;
      KEY_D:   return CALC_SUB;
      KEY_B:   return CALC_MULTI;
      default: return CALC_RST;
    endcase
  endfunction

endpackage

// File: rtl/calc_entry_fsm_bcd_entry_reg.sv
// rtl/calc_entry_fsm_bcd_entry_reg.sv - BCD operand shift register with digit count and backspace
module bcd_entry_reg #(
  parameter int DIGITS = 2,
  parameter int CW     = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                push,
  input  logic                pop,
  input  logic [3:0]          digit,
  output logic [4*DIGITS-1:0] value,
  output logic [CW-1:0]       cnt
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]  base_val, value_d;
  logic [CW-1:0] base_cnt, cnt_d;

  // clr composes with push so a fresh operand can start with one digit in a single cycle
  always_comb begin
    base_val = clr ? '0 : value;
    base_cnt = clr ? '0 : cnt;
    value_d  = base_val;
    cnt_d    = base_cnt;
    if (load) begin
      value_d = load_val;
      cnt_d   = '0;
    end else if (push && (base_cnt < CW'(DIGITS))) begin
      value_d = (base_val << 4) | W'(digit);
      cnt_d   = base_cnt + CW'(1);
    end else if (pop && (base_cnt != '0)) begin
      value_d = base_val >> 4;
      cnt_d   = base_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      cnt   <= '0;
    end else begin
      value <= value_d;
      cnt   <= cnt_d;
    end
  end

endmodule

// File: rtl/calc_entry_fsm.sv
// rtl/calc_entry_fsm.sv - keypad entry controller: edge detect, entry FSM, operand registers
module calc_entry_fsm #(
  parameter int DIGITS = 2,
  parameter int CW     = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          key,
  input  logic                pressed,
  input  logic [4*DIGITS-1:0] result,
  output logic [4*DIGITS-1:0] num_a,
  output logic [4*DIGITS-1:0] num_b,
  output logic [1:0]          calc,
  output logic [1:0]          state,
  output logic                disp_sel,
  output logic [CW-1:0]       digit_cnt,
  output logic                entry_full,
  output logic                key_ack
);

  import calc_entry_fsm_pkg::*;

  stat_e       state_q, state_d;
  logic [1:0]  calc_q, calc_d;
  logic        disp_q, disp_d;
  logic        pressed_q, armed_q, key_ack_q;
  logic        ev;
  logic        clr_a, load_a, push_a, pop_a;
  logic        clr_b, push_b, pop_b;
  logic [CW-1:0] cnt_a, cnt_b;

  // armed_q blocks a level still held across reset until pressed has been seen low
  assign ev = pressed & ~pressed_q & armed_q;

  always_comb begin
    state_d = state_q;
    calc_d  = calc_q;
    disp_d  = disp_q;
    clr_a   = 1'b0;
    load_a  = 1'b0;
    push_a  = 1'b0;
    pop_a   = 1'b0;
    clr_b   = 1'b0;
    push_b  = 1'b0;
    pop_b   = 1'b0;
    if (state_q == STAT_ILLEGAL) begin
      clr_a   = 1'b1;
      clr_b   = 1'b1;
      calc_d  = CALC_RST;
      disp_d  = DISP_ENTRY;
      state_d = STAT_NUM_A;
    end else if (ev && (key == KEY_F)) begin
      clr_a   = 1'b1;
      clr_b   = 1'b1;
      calc_d  = CALC_RST;
      disp_d  = DISP_ENTRY;
      state_d = STAT_NUM_A;
    end else if (ev) begin
      case (state_q)
        STAT_NUM_A: begin
          if (is_digit(key)) begin
            push_a = 1'b1;
          end else if (key == KEY_C) begin
            pop_a = 1'b1;
          end else if (is_op(key)) begin
            calc_d  = op_code(key);
            clr_b   = 1'b1;
            state_d = STAT_NUM_B;
          end
        end
        STAT_NUM_B: begin
          if (is_digit(key)) begin
            push_b = 1'b1;
          end else if (key == KEY_C) begin
            pop_b = 1'b1;
          end else if (key == KEY_E) begin
            disp_d  = DISP_RESULT;
            state_d = STAT_RESULT;
          end
        end
        STAT_RESULT: begin
          if (is_op(key)) begin
            load_a  = 1'b1;
            clr_b   = 1'b1;
            calc_d  = op_code(key);
            disp_d  = DISP_ENTRY;
            state_d = STAT_NUM_B;
          end else if (is_digit(key)) begin
            clr_a   = 1'b1;
            push_a  = 1'b1;
            clr_b   = 1'b1;
            calc_d  = CALC_RST;
            disp_d  = DISP_ENTRY;
            state_d = STAT_NUM_A;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= STAT_NUM_A;
      calc_q    <= CALC_RST;
      disp_q    <= DISP_ENTRY;
      pressed_q <= 1'b0;
      armed_q   <= 1'b0;
      key_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      calc_q    <= calc_d;
      disp_q    <= disp_d;
      pressed_q <= pressed;
      armed_q   <= armed_q | ~pressed;
      key_ack_q <= ev;
    end
  end

  bcd_entry_reg #(.DIGITS(DIGITS), .CW(CW)) u_reg_a (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_a),
    .load     (load_a),
    .load_val (result),
    .push     (push_a),
    .pop      (pop_a),
    .digit    (key),
    .value    (num_a),
    .cnt      (cnt_a)
  );

  bcd_entry_reg #(.DIGITS(DIGITS), .CW(CW)) u_reg_b (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_b),
    .load     (1'b0),
    .load_val ('0),
    .push     (push_b),
    .pop      (pop_b),
    .digit    (key),
    .value    (num_b),
    .cnt      (cnt_b)
  );

  assign state      = state_q;
  assign calc       = calc_q;
  assign disp_sel   = disp_q;
  assign key_ack    = key_ack_q;
  // RESULT keeps showing operand B's count, which is the last operand edited
  assign digit_cnt  = (state_q == STAT_NUM_A) ? cnt_a : cnt_b;
  assign entry_full = (digit_cnt == CW'(DIGITS));

endmodule

// File: tb/tb_calc_entry_fsm.sv
// tb/tb_calc_entry_fsm.sv - directed self-checking bench for calc_entry_fsm at DIGITS=2 and DIGITS=4
module tb_calc_entry_fsm;

  import calc_entry_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key;
  logic        p2, p4;
  logic [7:0]  res2;
  logic [15:0] res4;

  logic [7:0]  a2, b2;
  logic [1:0]  calc2, st2, cnt2;
  logic        disp2, full2, ack2;
  logic [15:0] a4, b4;
  logic [1:0]  calc4, st4;
  logic [2:0]  cnt4;
  logic        disp4, full4, ack4;

  int tests = 0;
  int fails = 0;
  int ack_cnt2 = 0;
  int ack_mark;

  always #5 clk = ~clk;

  calc_entry_fsm #(.DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .key(key), .pressed(p2), .result(res2),
    .num_a(a2), .num_b(b2), .calc(calc2), .state(st2), .disp_sel(disp2),
    .digit_cnt(cnt2), .entry_full(full2), .key_ack(ack2)
  );

  calc_entry_fsm #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .key(key), .pressed(p4), .result(res4),
    .num_a(a4), .num_b(b4), .calc(calc4), .state(st4), .disp_sel(disp4),
    .digit_cnt(cnt4), .entry_full(full4), .key_ack(ack4)
  );

  always @(negedge clk) if (ack2 === 1'b1) ack_cnt2 = ack_cnt2 + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press2(input logic [3:0] k);
    @(negedge clk); key = k; p2 = 1'b1;
    @(negedge clk); p2 = 1'b0;
    @(negedge clk); #2;
  endtask

  task automatic press4(input logic [3:0] k);
    @(negedge clk); key = k; p4 = 1'b1;
    @(negedge clk); p4 = 1'b0;
    @(negedge clk); #2;
  endtask

  initial begin
    rst = 1'b1; key = KEY_0; p2 = 1'b0; p4 = 1'b0; res2 = 8'h00; res4 = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_num_a", a2, 8'h00);
    chk("rst_num_b", b2, 8'h00);
    chk("rst_calc", calc2, CALC_RST);
    chk("rst_state", st2, 2'b10);
    chk("rst_disp", disp2, 1'b0);
    chk("rst_cnt", cnt2, 0);
    chk("rst_full", full2, 1'b0);
    chk("rst_ack", ack2, 1'b0);
    chk("rst4_state", st4, 2'b10);

    ack_mark = ack_cnt2;
    press2(KEY_1); press2(KEY_2);
    chk("two_digits_full", full2, 1'b1);
    press2(KEY_3);
    chk("overflow_num_a", a2, 8'h12);
    chk("overflow_cnt", cnt2, 2);
    chk("overflow_full", full2, 1'b1);
    chk("overflow_acks", ack_cnt2 - ack_mark, 3);

    press2(KEY_F);
    press2(KEY_E);
    chk("e_in_num_a_state", st2, 2'b10);
    press2(KEY_4); press2(KEY_7); press2(KEY_C);
    chk("bksp_num_a", a2, 8'h04);
    chk("bksp_cnt", cnt2, 1);
    press2(KEY_5);
    chk("bksp_then_digit", a2, 8'h45);
    chk("bksp_then_cnt", cnt2, 2);
    press2(KEY_C); press2(KEY_C); press2(KEY_C);
    chk("bksp_empty_num_a", a2, 8'h00);
    chk("bksp_empty_cnt", cnt2, 0);

    press2(KEY_9); press2(KEY_A);
    chk("op_state", st2, 2'b11);
    chk("op_cnt", cnt2, 0);
    press2(KEY_3); press2(KEY_B);
    chk("op_in_b_ignored", calc2, CALC_ADD);
    press2(KEY_E);
    chk("eq_calc", calc2, CALC_ADD);
    chk("eq_num_a", a2, 8'h09);
    chk("eq_num_b", b2, 8'h03);
    chk("eq_state", st2, 2'b01);
    chk("eq_disp", disp2, 1'b1);
    chk("eq_cnt", cnt2, 1);

    res2 = 8'h12;
    press2(KEY_D);
    res2 = 8'h77;
    chk("chain_num_a", a2, 8'h12);
    chk("chain_num_b", b2, 8'h00);
    chk("chain_calc", calc2, CALC_SUB);
    chk("chain_state", st2, 2'b11);
    chk("chain_disp", disp2, 1'b0);
    chk("chain_cnt", cnt2, 0);

    press2(KEY_7); press2(KEY_E); press2(KEY_C);
    chk("c_in_result_state", st2, 2'b01);
    chk("c_in_result_num_b", b2, 8'h07);
    press2(KEY_6);
    chk("digit_res_num_a", a2, 8'h06);
    chk("digit_res_num_b", b2, 8'h00);
    chk("digit_res_calc", calc2, CALC_RST);
    chk("digit_res_cnt", cnt2, 1);
    chk("digit_res_state", st2, 2'b10);
    chk("digit_res_disp", disp2, 1'b0);

    press2(KEY_F);
    ack_mark = ack_cnt2;
    @(negedge clk); key = KEY_5; p2 = 1'b1;
    repeat (10) @(negedge clk);
    p2 = 1'b0;
    @(negedge clk); #2;
    chk("hold_num_a", a2, 8'h05);
    chk("hold_cnt", cnt2, 1);
    chk("hold_acks", ack_cnt2 - ack_mark, 1);

    press2(KEY_F);
    @(negedge clk); key = KEY_8; p2 = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("prehold_num_a", a2, 8'h08);
    rst = 1'b1;
    #1;
    chk("async_rst_num_a", a2, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ack_mark = ack_cnt2;
    repeat (5) @(negedge clk);
    #2;
    chk("held_after_rst_num_a", a2, 8'h00);
    chk("held_after_rst_cnt", cnt2, 0);
    chk("held_after_rst_acks", ack_cnt2 - ack_mark, 0);
    p2 = 1'b0;
    @(negedge clk);
    press2(KEY_8);
    chk("rearm_num_a", a2, 8'h08);

    press4(KEY_1); press4(KEY_2); press4(KEY_3); press4(KEY_4); press4(KEY_5);
    chk("d4_num_a", a4, 16'h1234);
    chk("d4_cnt", cnt4, 4);
    chk("d4_full", full4, 1'b1);
    press4(KEY_F);
    chk("d4_clr_num_a", a4, 16'h0000);
    chk("d4_clr_num_b", b4, 16'h0000);
    chk("d4_clr_calc", calc4, CALC_RST);
    chk("d4_clr_state", st4, 2'b10);
    chk("d4_clr_disp", disp4, 1'b0);
    chk("d4_clr_cnt", cnt4, 0);
    chk("d4_clr_full", full4, 1'b0);
    chk("d4_clr_ack", ack4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
